hold_step_ctrl: RTL and testbench
=================================

// Module: hold_step_ctrl
// PURPOSE
// - Sequencer between the picoMIPS decoder and the PC. It owns the operator handshake on SW[8].
// - When the current instruction requests a hold (input-wait instruction), the PC is stalled until a
//   debounced press of SW[8]. The block then pulses a register-file load of SW[7:0], advances the PC
//   once and waits for release.
// - Replaces the combinational Switch8/HOLDen gating in the decoder with a clean, debounced FSM.
// PARAMETERS
// - DB_CYCLES  3                       consecutive stable samples required to accept a switch change (>=1)
// - CW         $clog2(DB_CYCLES+1)     debounce counter width (derived, not overridden)
// PORTS
// - clk        in   1  system clock (10 Hz board clock)
// - reset      in   1  asynchronous, active-low master reset
// - hold_req   in   1  decoder: current instruction must wait for operator (opcode hold and HOLDen)
// - sw_go      in   1  raw SW[8]; asynchronous to clk, may bounce
// - pc_en      out  1  PC advance enable for this cycle
// - sw_load    out  1  one-cycle strobe: write SW[7:0] into Rd (drives writeSelect and w)
// - waiting    out  1  high while stalled for the operator (LED indicator)
// BEHAVIOUR
// - Sync: 2-FF synchroniser sw_go->s1->s2. Both flops reset to 0.
// - Debounce: register go_db (reset 0) and counter cnt (reset 0).
//   - Each edge with s2==go_db: cnt<=0.
//   - Each edge with s2!=go_db: cnt<=cnt+1. When cnt+1==DB_CYCLES: go_db<=s2 and cnt<=0.
//   - Pulses shorter than DB_CYCLES samples never change go_db.
// - FSM states (reset -> RUN):
//   - RUN:        pc_en=!hold_req. If hold_req: go_db ? ARM : WAIT_PRESS. Else stay.
//   - ARM:        switch already high on entry. pc_en=0. Go to WAIT_PRESS when go_db==0.
//   - WAIT_PRESS: pc_en=0. Go to LOAD when go_db==1.
//   - LOAD:       sw_load=1 and pc_en=1 for exactly one cycle (steps past the hold instruction).
//                 Unconditionally -> WAIT_REL.
//   - WAIT_REL:   pc_en=0. Go to RUN when go_db==0.
// - waiting=1 in ARM, WAIT_PRESS, LOAD and WAIT_REL; 0 in RUN. sw_load=1 only in LOAD.
// - Outputs are Moore decodes of the state register. Exception: pc_en in RUN is gated by hold_req.
// - Reset values: state=RUN, sw_load=0, waiting=0, pc_en=!hold_req.
// - Latency: sw_go first sampled high at edge E0 and held stable.
//   go_db rises at E(DB_CYCLES+1); LOAD is entered at E(DB_CYCLES+2).
//   With DB_CYCLES=3, sw_load is high in the cycle following edge E5.
// - Each press yields exactly one sw_load, however long it is held. Back-to-back hold instructions
//   each need a separate release+press; a hold_req seen during WAIT_REL is acted on in RUN.
// - hold_req is sampled only in RUN; changes in other states are ignored.
// - reset asserted in any state: immediate return to RUN, counters cleared, and no sw_load pulse.
//   A press in progress is discarded.
// - Only DB_CYCLES=1 bypasses filtering (go_db follows s2 with one edge delay).
// CONFIGURATION
// - Macro SINGLE_STEP_EN.
// - Defined: adds input port step_mode (1 bit, after sw_go). With step_mode=1, RUN treats every
//   instruction as held. One instruction executes per debounced press: LOAD gives pc_en=1, while
//   sw_load=hold_req. step_mode is sampled only in RUN.
// - Not defined: port absent; behaviour identical to step_mode=0.
// TESTING (DB_CYCLES=3)
// 1. hold_req=0 for 20 cycles, sw_go toggling -> pc_en=1 every cycle, waiting=0, sw_load=0.
// 2. hold_req=1, then sw_go=1 from E0 for 12 cycles, then 0 ->
//    - waiting=1 from the first edge after hold_req.
//    - single sw_load with pc_en=1 after E5.
//    - waiting returns to 0 five edges after release.
// 3. In WAIT_PRESS, sw_go high 2 cycles then low, repeated 5 times -> go_db stays 0, no sw_load, pc_en=0.
// 4. sw_go held 1 before hold_req rises -> state ARM, no sw_load. After release and a fresh 4-cycle
//    press -> exactly one sw_load.
// 5. reset driven low asynchronously mid-debounce in WAIT_PRESS (cnt=2) -> state RUN, cnt=0, go_db=0,
//    sw_load=0 immediately. After release, normal operation.
// 6. SINGLE_STEP_EN, step_mode=1, hold_req=0 -> pc_en=0 until press; one pc_en pulse per press;
//    sw_load stays 0.

Source files
------------

// File: rtl/hold_step_ctrl.sv
// hold_step_ctrl: stalls the PC on hold instructions until a debounced SW[8] press, then loads SW[7:0] and steps once.
// Optional macro SINGLE_STEP_EN adds a step_mode input that treats every instruction as held.
module hold_step_ctrl #(
    parameter  int unsigned DB_CYCLES = 3,
    localparam int unsigned CW        = $clog2(DB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic hold_req,
    input  logic sw_go,
`ifdef SINGLE_STEP_EN
    input  logic step_mode,
`endif
    output logic pc_en,
    output logic sw_load,
    output logic waiting
);

    typedef enum logic [2:0] {
        RUN,
        ARM,
        WAIT_PRESS,
        LOAD,
        WAIT_REL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          s1;
    logic          s2;
    logic          go_db;
    logic [CW-1:0] cnt;
    logic          held;
    logic          load_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_go;
            s2 <= s1;
        end
    end

    // go_db flips only after DB_CYCLES consecutive samples that disagree with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go_db <= 1'b0;
            cnt   <= '0;
        end else if (s2 == go_db) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            go_db <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef SINGLE_STEP_EN
    logic load_hold;

    always_comb begin
        held = hold_req | step_mode;
    end

    // remember, while still in RUN, whether the stall came from a real hold instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_hold <= 1'b0;
        end else if (state == RUN) begin
            load_hold <= hold_req;
        end
    end

    always_comb begin
        load_sel = load_hold;
    end
`else
    always_comb begin
        held     = hold_req;
        load_sel = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (held) state_nxt = go_db ? ARM : WAIT_PRESS;
            ARM:        if (!go_db) state_nxt = WAIT_PRESS;
            WAIT_PRESS: if (go_db) state_nxt = LOAD;
            LOAD:       state_nxt = WAIT_REL;
            WAIT_REL:   if (!go_db) state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_en   = 1'b0;
        sw_load = 1'b0;
        waiting = 1'b1;
        case (state)
            RUN: begin
                pc_en   = !held;
                waiting = 1'b0;
            end
            LOAD: begin
                pc_en   = 1'b1;
                sw_load = load_sel;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hold_step_ctrl.sv
// Scoreboard bench for hold_step_ctrl: a behavioural handshake model queues expected outputs, a monitor compares them.
module tb_hold_step_ctrl;

    localparam int unsigned DB = 3;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic hold_req = 1'b0;
    logic sw_go    = 1'b0;
    logic pc_en;
    logic sw_load;
    logic waiting;

    typedef struct {
        logic pc_en;
        logic sw_load;
        logic waiting;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // reference model: synchroniser delay line, sample history, operator handshake flags
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_go = 1'b0;
    logic hist[$];
    bit   m_waiting  = 1'b0;
    bit   m_step     = 1'b0;
    bit   m_need_low = 1'b0;
    bit   m_after    = 1'b0;

    hold_step_ctrl #(.DB_CYCLES(DB)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .hold_req (hold_req),
        .sw_go    (sw_go),
        .pc_en    (pc_en),
        .sw_load  (sw_load),
        .waiting  (waiting)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic got, input logic want, input int c);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, c, got, want);
        end
    endtask

    task automatic model_clear();
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        m_go       = 1'b0;
        hist.delete();
        m_waiting  = 1'b0;
        m_step     = 1'b0;
        m_need_low = 1'b0;
        m_after    = 1'b0;
    endtask

    task automatic model_edge();
        logic old_go;
        bit   all_diff;
        if (!rst_n) begin
            model_clear();
            return;
        end
        old_go = m_go;
        if (!m_waiting) begin
            if (hold_req) begin
                m_waiting  = 1'b1;
                m_need_low = old_go;
                m_after    = 1'b0;
                m_step     = 1'b0;
            end
        end else if (m_step) begin
            m_step  = 1'b0;
            m_after = 1'b1;
        end else if (m_after) begin
            if (!old_go) begin
                m_waiting = 1'b0;
                m_after   = 1'b0;
            end
        end else if (m_need_low) begin
            if (!old_go) m_need_low = 1'b0;
        end else if (old_go) begin
            m_step = 1'b1;
        end
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        if (hist.size() == DB) begin
            all_diff = 1'b1;
            foreach (hist[k]) if (hist[k] == m_go) all_diff = 1'b0;
            if (all_diff) m_go = ~m_go;
        end
        m_s2 = m_s1;
        m_s1 = sw_go;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.pc_en   = m_waiting ? m_step : !hold_req;
        e.sw_load = m_step;
        e.waiting = m_waiting;
        e.cyc     = cyc;
        return e;
    endfunction

    task automatic drive(input logic rst, input logic hr, input logic sw, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n    = rst;
            hold_req = hr;
            sw_go    = sw;
            if (!rst) model_clear();
            @(posedge clk);
            cyc++;
            model_edge();
            exp_q.push_back(expect_now());
        end
    endtask

    // asynchronous reset dropped mid-cycle while the debounce counter is part way through a press
    task automatic async_reset_check();
        exp_t e;
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        e = expect_now();
        check("async_rst_waiting", waiting, e.waiting, cyc);
        check("async_rst_sw_load", sw_load, e.sw_load, cyc);
        check("async_rst_pc_en", pc_en, e.pc_en, cyc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_en", pc_en, e.pc_en, e.cyc);
                check("sw_load", sw_load, e.sw_load, e.cyc);
                check("waiting", waiting, e.waiting, e.cyc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int len;
        drive(1'b0, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b0, 1);

        // free run with a toggling switch
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1);
        drive(1'b1, 1'b0, 1'b0, 6);

        // hold then a long press and release
        drive(1'b1, 1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b1, 12);
        drive(1'b1, 1'b0, 1'b0, 8);

        // short glitches while waiting for a press
        drive(1'b1, 1'b1, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b1, 2);
            drive(1'b1, 1'b1, 1'b0, 2);
        end
        drive(1'b1, 1'b0, 1'b1, 8);
        drive(1'b1, 1'b0, 1'b0, 8);

        // switch already high when the hold arrives
        drive(1'b1, 1'b0, 1'b1, 6);
        drive(1'b1, 1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 1'b0, 6);
        drive(1'b1, 1'b0, 1'b1, 4);
        drive(1'b1, 1'b0, 1'b0, 8);

        // back-to-back holds
        drive(1'b1, 1'b1, 1'b1, 8);
        drive(1'b1, 1'b1, 1'b0, 8);
        drive(1'b1, 1'b1, 1'b1, 8);
        drive(1'b1, 1'b0, 1'b0, 8);

        // async reset with counter at 2 inside WAIT_PRESS
        drive(1'b1, 1'b1, 1'b0, 3);
        drive(1'b1, 1'b0, 1'b1, 4);
        async_reset_check();
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b1, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b1, 1'b1, 6);
        drive(1'b1, 1'b0, 1'b0, 8);

        // randomized switch activity, hold requests and occasional resets
        for (int i = 0; i < 400; i++) begin
            len = int'($urandom_range(1, 8));
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 2)));
            end else begin
                drive(1'b1, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), len);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 10);

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
